// File: rtl/audio_sample_feeder.sv
// Stereo sample FIFO between demodulator and I2S driver; output words updated on FRAME_REQ.
// Latency: the popped word appears on DATA_L/DATA_R on the same edge that sees FRAME_REQ; the I2S driver consumes it one frame later.
// Backpressure: IN_READY low only when full; an empty FIFO in RUN flags sticky UNDERRUN and refills. Option: FEEDER_MUTE_ON_UNDERRUN_EN.
module audio_sample_feeder #(
    parameter int BUS_WIDTH  = 16,
    parameter int DEPTH_LOG2 = 4,
    parameter int PREFILL    = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [0:BUS_WIDTH-1]  IN_L,
    input  logic [0:BUS_WIDTH-1]  IN_R,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    input  logic                  FRAME_REQ,
    output logic [0:BUS_WIDTH-1]  DATA_L,
    output logic [0:BUS_WIDTH-1]  DATA_R,
    output logic [DEPTH_LOG2:0]   LEVEL,
    output logic                  UNDERRUN
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LVL    = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] PREFILL_LVL = (DEPTH_LOG2 + 1)'(PREFILL);

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                 state;
    logic [DEPTH_LOG2-1:0]  wr_ptr;
    logic [DEPTH_LOG2-1:0]  rd_ptr;
    logic [0:BUS_WIDTH-1]   mem_l [DEPTH];
    logic [0:BUS_WIDTH-1]   mem_r [DEPTH];
    logic                   push_vld;
    logic                   pop_vld;
    logic                   level_zero;

    assign IN_READY   = (LEVEL != FULL_LVL);
    assign level_zero = (LEVEL == '0);
    assign push_vld   = IN_VALID & IN_READY;
    // Pop only reads registered LEVEL, so a same-cycle push into an empty FIFO is never bypassed.
    assign pop_vld    = (state == ST_RUN) & FRAME_REQ & ~level_zero;

    // Storage is left uninitialised on reset; pointers and LEVEL alone define validity.
    always_ff @(posedge CLK) begin
        if (push_vld) begin
            mem_l[wr_ptr] <= IN_L;
            mem_r[wr_ptr] <= IN_R;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= ST_FILL;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            LEVEL    <= '0;
            DATA_L   <= '0;
            DATA_R   <= '0;
            UNDERRUN <= 1'b0;
        end else begin
            if (push_vld) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_vld) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            LEVEL <= LEVEL + (DEPTH_LOG2 + 1)'(push_vld) - (DEPTH_LOG2 + 1)'(pop_vld);

            case (state)
                ST_FILL: begin
                    if (FRAME_REQ) begin
                        DATA_L <= '0;
                        DATA_R <= '0;
                    end
                    if (LEVEL >= PREFILL_LVL) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (FRAME_REQ) begin
                        if (!level_zero) begin
                            DATA_L <= mem_l[rd_ptr];
                            DATA_R <= mem_r[rd_ptr];
                        end else begin
                            UNDERRUN <= 1'b1;
                            state    <= ST_FILL;
`ifdef FEEDER_MUTE_ON_UNDERRUN_EN
                            DATA_L   <= '0;
                            DATA_R   <= '0;
`endif
                        end
                    end
                end
                default: state <= ST_FILL;
            endcase
        end
    end

endmodule

// File: doc/audio_sample_feeder.md
AUDIO_SAMPLE_FEEDER -- requirements
Module: audio_sample_feeder

Interface
REQ-001 Parameter BUS_WIDTH, default 16, sample word width per channel; two's complement; index 0 = MSB on all sample ports.
REQ-002 Parameter DEPTH_LOG2, default 4, FIFO depth = 2**DEPTH_LOG2 stereo entries.
REQ-003 Parameter PREFILL, default 8, level at which FILL exits to RUN; legal range 1..2**DEPTH_LOG2.
REQ-004 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-005 CLK  in  1  sole clock, all logic on rising edge.
REQ-006 RST  in  1  synchronous active-high reset.
REQ-007 IN_L  in  [0:BUS_WIDTH-1]  left sample from demodulator.
REQ-008 IN_R  in  [0:BUS_WIDTH-1]  right sample from demodulator.
REQ-009 IN_VALID  in  1  IN_L/IN_R valid this cycle.
REQ-010 IN_READY  out  1  FIFO can accept; push = IN_VALID & IN_READY.
REQ-011 FRAME_REQ  in  1  one-cycle pulse per I2S frame (driven from the I2S driver LATCH strobe).
REQ-012 DATA_L  out  [0:BUS_WIDTH-1]  held left word to I2S driver.
REQ-013 DATA_R  out  [0:BUS_WIDTH-1]  held right word to I2S driver.
REQ-014 LEVEL  out  DEPTH_LOG2+1  current FIFO occupancy, 0..2**DEPTH_LOG2.
REQ-015 UNDERRUN  out  1  sticky: a FRAME_REQ found the FIFO empty while in RUN.

Function
REQ-016 IN_READY shall equal (LEVEL != 2**DEPTH_LOG2), combinational from registered LEVEL only; no dependence on FRAME_REQ.
REQ-017 Push shall write {IN_L,IN_R} at write pointer; pointers DEPTH_LOG2 bits, wrap modulo depth.
REQ-018 State machine states FILL, RUN; FILL after reset.
REQ-019 FILL: FRAME_REQ shall not pop; DATA_L/DATA_R driven to zero on each FRAME_REQ; transition to RUN on the edge where registered LEVEL >= PREFILL.
REQ-020 RUN, FRAME_REQ with LEVEL != 0: pop head entry; DATA_L/DATA_R updated on that same edge (the I2S driver captures the prior value; one-frame latency is intended).
REQ-021 RUN, FRAME_REQ with LEVEL == 0: no pop; set UNDERRUN; outputs per REQ-030; transition to FILL.
REQ-022 DATA_L/DATA_R shall change only on edges where FRAME_REQ is high or RST is high; stable for a full frame otherwise.
REQ-023 Simultaneous push and pop: LEVEL unchanged; both pointers advance.
REQ-024 Push into empty FIFO concurrent with FRAME_REQ: pop sees LEVEL==0 (no bypass); entry is stored; underrun per REQ-021.
REQ-025 Push when full: not accepted (IN_READY low), even if a pop occurs the same cycle.
REQ-026 UNDERRUN cleared only by RST.
REQ-027 FRAME_REQ high for multiple consecutive cycles: each high cycle is a separate request.

Reset
REQ-028 On RST: state FILL, pointers 0, LEVEL 0, DATA_L/DATA_R 0, UNDERRUN 0; FIFO storage not cleared.
REQ-029 RST mid-operation discards all stored samples; RST overrides simultaneous push/FRAME_REQ.

Configuration
REQ-030 Macro FEEDER_MUTE_ON_UNDERRUN_EN: defined -> underrun drives DATA_L/DATA_R to zero; undefined -> underrun holds last output words unchanged.

Verification
REQ-031 Reset, push 8 entries (L=0x0100+n, R=0x0200+n) -> state RUN, LEVEL=8, DATA outputs still 0.
REQ-032 From REQ-031, 3 FRAME_REQ pulses -> DATA_L=0x0102, DATA_R=0x0202, LEVEL=5.
REQ-033 Push 16 with no FRAME_REQ -> IN_READY=0, LEVEL=16; 17th push ignored; pops return entries 0..15 in order across pointer wrap.
REQ-034 Drain FIFO then one extra FRAME_REQ -> UNDERRUN=1, state FILL; DATA=0 with macro, last word (e.g. 0x010F/0x020F) held without.
REQ-035 Push and FRAME_REQ same cycle at LEVEL=4 -> LEVEL stays 4, DATA = head entry; RST asserted mid-stream -> all outputs 0, LEVEL 0 next cycle.
